divider_arbiter: RTL and testbench

Shares one iterative `divider` instance (start/done handshake, N-bit unsigned quotient) among NUM_REQ requesters, typically the per-thread ALUs of a core. It grants requesters round-robin, latches the winner's operands and pulses the divider's start. It waits for done and returns the quotient to the granted requester only. Divide-by-zero is resolved locally and never reaches the divider.

---
 rtl/divider_arbiter_pkg.sv | 18 +
 rtl/divider_arbiter_rr_picker.sv | 27 ++
 rtl/divider_arbiter.sv | 94 +++++++++
 tb/tb_divider_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter and its picker.
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // A divide-by-zero returns a quotient with every bit set to this value.
  localparam logic DIV_ZERO_FILL = 1'b1;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
module rr_picker
  import divider_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      grant,
  output logic               any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one iterative divider among NUM_REQ requesters with round-robin grants;
// divide-by-zero is answered locally without starting the divider.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [N-1:0]         resp_result,
  output logic                 resp_div_zero,
  output logic                 busy,
  output logic                 div_start,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [N-1:0]         div_result,
  input  logic                 div_done
);

  localparam int GW = grant_w(NUM_REQ);
  localparam logic [N-1:0] DIV_ZERO_RESULT = {N{DIV_ZERO_FILL}};

  // Handshake: req_valid is a level held until the one-cycle resp_valid pulse
  // for that requester; div_start is a one-cycle pulse and div_done is only
  // honoured in WAIT, so a done left high from a previous divide is ignored.

  state_t         state;
  state_t         state_next;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  pick;
  logic           pick_any;
  logic [N-1:0]   pick_dividend;
  logic [N-1:0]   pick_divisor;

  rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  assign pick_dividend = req_dividend[int'(pick)*N +: N];
  assign pick_divisor  = req_divisor[int'(pick)*N +: N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= GW'(NUM_REQ - 1);
      grant_q       <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      resp_result   <= '0;
      resp_div_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_any) begin
        ptr           <= pick;
        grant_q       <= pick;
        div_dividend  <= pick_dividend;
        div_divisor   <= pick_divisor;
        resp_div_zero <= (pick_divisor == '0);
        resp_result   <= (pick_divisor == '0) ? DIV_ZERO_RESULT : '0;
      end
      if (state == WAIT && div_done) begin
        resp_result <= div_result;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = (pick_divisor == '0) ? RESPOND : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (div_done) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESPOND) resp_valid[grant_q] = 1'b1;
    div_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider and a response scoreboard.
module tb_divider_arbiter;

  localparam int N   = 8;
  localparam int NR  = 4;
  localparam int LAT = 3;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*N-1:0] req_dividend;
  logic [NR*N-1:0] req_divisor;
  logic [NR-1:0]   resp_valid;
  logic [N-1:0]    resp_result;
  logic            resp_div_zero;
  logic            busy;
  logic            div_start;
  logic [N-1:0]    div_dividend;
  logic [N-1:0]    div_divisor;
  logic [N-1:0]    div_result;
  logic            div_done;

  divider_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_result   (resp_result),
    .resp_div_zero (resp_div_zero),
    .busy          (busy),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_result    (div_result),
    .div_done      (div_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int resp_cnt[NR];
  int drop_after[NR];
  logic stale_mode;

  logic [12:0] exp_q[$];    // {requester index, quotient, div_zero}
  logic [15:0] start_q[$];  // {dividend, divisor}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural divider; stale_mode leaves done high until the next start
  logic [N-1:0] m_q;
  logic         m_busy;
  int           m_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      m_q        <= '0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else if (div_start) begin
      m_busy   <= 1'b1;
      m_cnt    <= LAT;
      div_done <= 1'b0;
      m_q      <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        div_done   <= 1'b1;
        div_result <= m_q;
        m_busy     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!stale_mode) begin
      div_done <= 1'b0;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (div_start) begin
        start_cnt++;
        if (start_q.size() == 0) begin
          check("unexpected_div_start", 32'd1, 32'd0);
        end else begin
          logic [15:0] s;
          s = start_q.pop_front();
          check("div_operands", {16'd0, div_dividend, div_divisor}, {16'd0, s});
        end
      end
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {28'd0, resp_valid}, 32'd0);
        end else begin
          logic [12:0] e;
          logic [NR-1:0] oh;
          e  = exp_q.pop_front();
          oh = '0;
          oh[e[12:9]] = 1'b1;
          check("resp_valid", {28'd0, resp_valid}, {28'd0, oh});
          check("resp_result", {24'd0, resp_result}, {24'd0, e[8:1]});
          check("resp_div_zero", {31'd0, resp_div_zero}, {31'd0, e[0]});
        end
      end
    end
  end

  // requesters drop req_valid after their configured number of responses
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (reset && resp_valid[i]) begin
        resp_cnt[i]++;
        if (resp_cnt[i] >= drop_after[i]) req_valid[i] = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    req_valid  = '0;
    stale_mode = 1'b0;
    for (int i = 0; i < NR; i++) begin
      resp_cnt[i]   = 0;
      drop_after[i] = 1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input int drop);
    req_dividend[i*N +: N] = a;
    req_divisor[i*N +: N]  = b;
    resp_cnt[i]   = 0;
    drop_after[i] = drop;
    req_valid[i]  = 1'b1;
  endtask

  task automatic expect_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] res, input logic dz);
    logic [3:0] idx;
    idx = 4'(i);
    exp_q.push_back({idx, res, dz});
    if (!dz) start_q.push_back({a, b});
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 2000;
    while ((exp_q.size() != 0 || busy || req_valid != '0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_timeout"}, {31'd0, budget == 0}, 32'd0);
  endtask

  initial begin
    int sc;
    int budget;
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    stale_mode   = 1'b0;

    // reset state
    do_reset();
    check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("rst_resp_result", {24'd0, resp_result}, 32'd0);
    check("rst_resp_div_zero", {31'd0, resp_div_zero}, 32'd0);
    check("rst_div_start", {31'd0, div_start}, 32'd0);
    check("rst_div_dividend", {24'd0, div_dividend}, 32'd0);
    check("rst_div_divisor", {24'd0, div_divisor}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // single requester 0: 200/7 = 28
    expect_op(0, 8'd200, 8'd7, 8'd28, 1'b0);
    drive(0, 8'd200, 8'd7, 1);
    wait_drain("single");

    // divide by zero on requester 2: answered the cycle after the request
    do_reset();
    sc = start_cnt;
    expect_op(2, 8'd55, 8'd0, 8'hFF, 1'b1);
    drive(2, 8'd55, 8'd0, 1);
    @(posedge clk);
    @(negedge clk);
    check("dz_latency", {28'd0, resp_valid}, 32'h4);
    wait_drain("div_zero");
    check("dz_no_start", sc, start_cnt);

    // all four at once -> 0,1,2,3
    do_reset();
    expect_op(0, 8'd100, 8'd3, 8'd33, 1'b0);
    expect_op(1, 8'd90, 8'd9, 8'd10, 1'b0);
    expect_op(2, 8'd255, 8'd16, 8'd15, 1'b0);
    expect_op(3, 8'd7, 8'd8, 8'd0, 1'b0);
    drive(0, 8'd100, 8'd3, 1);
    drive(1, 8'd90, 8'd9, 1);
    drive(2, 8'd255, 8'd16, 1);
    drive(3, 8'd7, 8'd8, 1);
    wait_drain("all_four");

    // requesters 1 and 3 hold req_valid: grants alternate 1,3,1,3
    do_reset();
    expect_op(1, 8'd20, 8'd4, 8'd5, 1'b0);
    expect_op(3, 8'd21, 8'd7, 8'd3, 1'b0);
    expect_op(1, 8'd20, 8'd4, 8'd5, 1'b0);
    expect_op(3, 8'd21, 8'd7, 8'd3, 1'b0);
    drive(1, 8'd20, 8'd4, 2);
    drive(3, 8'd21, 8'd7, 2);
    wait_drain("alternate");

    // done left high between operations must not be taken as the new result
    do_reset();
    stale_mode = 1'b1;
    expect_op(0, 8'd10, 8'd2, 8'd5, 1'b0);
    drive(0, 8'd10, 8'd2, 1);
    wait_drain("stale_first");
    check("stale_done_high", {31'd0, div_done}, 32'd1);
    expect_op(0, 8'd9, 8'd3, 8'd3, 1'b0);
    drive(0, 8'd9, 8'd3, 1);
    wait_drain("stale_second");
    stale_mode = 1'b0;

    // reset while waiting for the divider abandons the operation
    do_reset();
    start_q.push_back({8'd100, 8'd5});
    drive(0, 8'd100, 8'd5, 1);
    budget = 50;
    while (!div_start && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("rst_wait_start_timeout", {31'd0, budget == 0}, 32'd0);
    @(negedge clk);
    check("in_wait_busy", {31'd0, busy}, 32'd1);
    reset     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_resp_valid", {28'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_op(0, 8'd50, 8'd5, 8'd10, 1'b0);
    expect_op(1, 8'd40, 8'd8, 8'd5, 1'b0);
    expect_op(2, 8'd30, 8'd2, 8'd15, 1'b0);
    drive(0, 8'd50, 8'd5, 1);
    drive(1, 8'd40, 8'd8, 1);
    drive(2, 8'd30, 8'd2, 1);
    wait_drain("after_reset");

    check("exp_q_empty", exp_q.size(), 0);
    check("start_q_empty", start_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
